// File: rtl/char_cmd_writer_pkg.sv
// char_cmd_writer_pkg: shared text-path constants, opcodes and sequencer state type.
package char_cmd_writer_pkg;
    localparam int CHAR_W_DEF = 6;
    localparam int COLS_DEF = 16;
    localparam logic [CHAR_W_DEF-1:0] BLANK_CHAR_DEF = 6'h3F;
    localparam logic [1:0] OP_PUTC = 2'b00;
    localparam logic [1:0] OP_SETCUR = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_BURST} state_e;
endpackage

// File: rtl/char_cmd_writer.sv
// char_cmd_writer: decodes command bytes into row-buffer write strobes with cursor and fill/clear bursts.
// Define CHAR_CMD_WRITER_VBLANK_EN to add a vblank input that gates every write.
module char_cmd_writer
    import char_cmd_writer_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int CHAR_W = CHAR_W_DEF,
    parameter logic [CHAR_W-1:0] BLANK_CHAR = BLANK_CHAR_DEF,
    localparam int AW = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CHAR_CMD_WRITER_VBLANK_EN
    input  logic              vblank,
`endif
    input  logic [7:0]        cmd_byte,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [CHAR_W-1:0] wr_char,
    output logic [AW-1:0]     cursor,
    output logic              busy
);
    state_e state_q, state_d;
    logic ready_q, ready_d, wr_en_q, wr_en_d, busy_q, busy_d, issue, go;
    logic [AW-1:0] addr_q, addr_d, cursor_q, cursor_d, cnt_q, cnt_d;
    logic [CHAR_W-1:0] char_q, char_d, pend_q, pend_d;
    logic [1:0] op;
`ifdef CHAR_CMD_WRITER_VBLANK_EN
    assign go = vblank;
`else
    assign go = 1'b1;
`endif
    assign op = cmd_byte[7:6];
    // cnt_q is the next column to write and pend_q the pending code, so a stalled write holds wr_addr/wr_char
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        wr_en_d = 1'b0;
        busy_d = busy_q;
        addr_d = addr_q;
        char_d = char_q;
        cursor_d = cursor_q;
        cnt_d = cnt_q;
        pend_d = pend_q;
        issue = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && ready_q) begin
                    if (op == OP_SETCUR) begin
                        cursor_d = cmd_byte[AW-1:0];
                    end else begin
                        ready_d = 1'b0;
                        busy_d = op != OP_PUTC;
                        state_d = op == OP_PUTC ? S_WRITE : S_BURST;
                        pend_d = op == OP_CLEAR ? BLANK_CHAR : CHAR_W'(cmd_byte[5:0]);
                        cnt_d = op == OP_PUTC ? cursor_q : '0;
                        cursor_d = op == OP_PUTC ? cursor_q + AW'(1) : cursor_q;
                        issue = go;
                    end
                end
            end
            S_WRITE: begin
                if (wr_en_q) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    issue = go;
                end
            end
            S_BURST: begin
                if (wr_en_q && addr_q == AW'(COLS - 1)) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    busy_d = 1'b0;
                    cursor_d = '0;
                end else begin
                    issue = go;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            wr_en_d = 1'b1;
            addr_d = cnt_d;
            char_d = pend_d;
            cnt_d = cnt_d + AW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q <= 1'b0;
            addr_q <= '0;
            char_q <= '0;
            cursor_q <= '0;
            cnt_q <= '0;
            pend_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            wr_en_q <= wr_en_d;
            busy_q <= busy_d;
            addr_q <= addr_d;
            char_q <= char_d;
            cursor_q <= cursor_d;
            cnt_q <= cnt_d;
            pend_q <= pend_d;
        end
    end
    assign cmd_ready = ready_q;
    assign wr_en = wr_en_q;
    assign wr_addr = addr_q;
    assign wr_char = char_q;
    assign cursor = cursor_q;
    assign busy = busy_q;
endmodule
